// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins and RAM-side parallel bus for spi_slave
interface spi_slave_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    // master: SPI master plus RAM side; slave: the spi_slave block itself
    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave: 10-bit command frames in, 8-bit read data out on MISO
module spi_slave (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  rx_shift_q, rx_shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic        tx_busy_q, tx_busy_d;
    logic        rd_addr_done_q, rd_addr_done_d;
    logic [9:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        miso_q, miso_d;
    logic        abort;

    assign abort = bus.SS_n && (state_q != IDLE);

    always_comb begin
        state_d        = state_q;
        rx_shift_d     = rx_shift_q;
        bit_cnt_d      = bit_cnt_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_busy_d      = tx_busy_q;
        rd_addr_done_d = rd_addr_done_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 4'd0;
                tx_cnt_d  = 4'd0;
                tx_busy_d = 1'b0;
                miso_d    = 1'b0;
                if (!bus.SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_d = IDLE;
                end else begin
                    rx_shift_d[9] = bus.MOSI;
                    bit_cnt_d     = 4'd1;
                    if (!bus.MOSI)          state_d = WRITE;
                    else if (rd_addr_done_q) state_d = READ_DATA;
                    else                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    state_d = IDLE;
                end else if (bit_cnt_q < 4'd10) begin
                    // bits land in place, so the register holds the frame MSB-aligned
                    rx_shift_d[4'd9 - bit_cnt_q] = bus.MOSI;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        if (state_q == READ_ADD)  rd_addr_done_d = 1'b1;
                        if (state_q == READ_DATA) rd_addr_done_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            bit_cnt_d = 4'd0;
            tx_cnt_d  = 4'd0;
            tx_busy_d = 1'b0;
            miso_d    = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == 4'd8) begin
                tx_cnt_d  = 4'd0;
                tx_busy_d = 1'b0;
                miso_d    = 1'b0;
            end else begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                tx_cnt_d   = tx_cnt_q + 4'd1;
            end
        end else if ((state_q == READ_DATA) && bus.tx_valid) begin
            // bit 7 goes straight to MISO on the load edge
            miso_d     = bus.tx_data[7];
            tx_shift_d = {bus.tx_data[6:0], 1'b0};
            tx_cnt_d   = 4'd1;
            tx_busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rx_shift_q     <= 10'h000;
            bit_cnt_q      <= 4'd0;
            tx_shift_q     <= 8'h00;
            tx_cnt_q       <= 4'd0;
            tx_busy_q      <= 1'b0;
            rd_addr_done_q <= 1'b0;
            rx_data_q      <= 10'h000;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_shift_q     <= rx_shift_d;
            bit_cnt_q      <= bit_cnt_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_busy_q      <= tx_busy_d;
            rd_addr_done_q <= rd_addr_done_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.MISO     = miso_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed testbench for spi_slave with a small RAM model
module tb_spi_slave;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pulse_cnt;

    spi_slave_if bus ();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 00 latch write address, 01 write, 10 latch read address, 11 read
    logic [7:0] mem [256];
    logic [7:0] wr_addr, rd_addr, ram_dout;
    logic       ram_tx_valid;
    logic       stray_valid;
    logic [7:0] stray_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_tx_valid <= 1'b0;
            ram_dout     <= 8'h00;
        end else begin
            ram_tx_valid <= 1'b0;
            if (bus.rx_valid === 1'b1) begin
                case (bus.rx_data[9:8])
                    2'b00: wr_addr <= bus.rx_data[7:0];
                    2'b01: mem[wr_addr] <= bus.rx_data[7:0];
                    2'b10: rd_addr <= bus.rx_data[7:0];
                    default: begin
                        ram_dout     <= mem[rd_addr];
                        ram_tx_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tx_valid = ram_tx_valid | stray_valid;
    assign bus.tx_data  = stray_valid ? stray_data : ram_dout;

    always @(posedge clk) if (bus.rx_valid === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // E0..E10 of one frame; checks the strobe after E10
    task automatic start_frame(input logic [9:0] f);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = f[i];
            tick();
        end
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== f) begin
            errors++;
            $display("FAIL frame_%h: rx_valid=%b rx_data=%h, expected 1 / %h", f, bus.rx_valid, bus.rx_data, f);
        end
    endtask

    // E11, then SS_n high for one clk
    task automatic end_frame();
        bus.MOSI = 1'b0;
        tick();
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL strobe_len: rx_valid=%b after E11, expected 0", bus.rx_valid);
        end
        bus.SS_n = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== 3'd0) begin
            errors++;
            $display("FAIL back_to_idle: state=%0d, expected 0", dut.state_q);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rx_data !== 10'h000 || bus.rx_valid !== 1'b0 || bus.MISO !== 1'b0 ||
            dut.state_q !== 3'd0 || dut.rd_addr_done_q !== 1'b0 || dut.tx_busy_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rx_data=%h rx_valid=%b MISO=%b state=%0d rd=%b busy=%b, expected 000/0/0/0/0/0",
                     bus.rx_data, bus.rx_valid, bus.MISO, dut.state_q, dut.rd_addr_done_q, dut.tx_busy_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        start_frame(10'h012);
        checks++;
        if (dut.state_q !== 3'd2 || dut.rd_addr_done_q !== 1'b0) begin
            errors++;
            $display("FAIL write_state: state=%0d rd=%b, expected 2 / 0", dut.state_q, dut.rd_addr_done_q);
        end
        end_frame();
        start_frame(10'h1A5);
        end_frame();
    endtask

    task automatic test_read_addr();
        start_frame(10'h212);
        checks++;
        if (dut.state_q !== 3'd3 || dut.rd_addr_done_q !== 1'b1) begin
            errors++;
            $display("FAIL read_addr_state: state=%0d rd=%b, expected 3 / 1", dut.state_q, dut.rd_addr_done_q);
        end
        end_frame();
    endtask

    task automatic test_read_data();
        logic [7:0] exp_byte;
        exp_byte = 8'hA5;
        start_frame(10'h300);
        checks++;
        if (dut.state_q !== 3'd4 || dut.rd_addr_done_q !== 1'b0) begin
            errors++;
            $display("FAIL read_data_state: state=%0d rd=%b, expected 4 / 0", dut.state_q, dut.rd_addr_done_q);
        end
        bus.MOSI = 1'b0;
        tick();                         // E11: RAM raises tx_valid
        for (int k = 7; k >= 0; k--) begin
            tick();                     // E12..E19
            checks++;
            if (bus.MISO !== exp_byte[k]) begin
                errors++;
                $display("FAIL miso_bit%0d: MISO=%b, expected %b", k, bus.MISO, exp_byte[k]);
            end
        end
        tick();                         // E20
        checks++;
        if (bus.MISO !== 1'b0 || dut.tx_busy_q !== 1'b0) begin
            errors++;
            $display("FAIL miso_done: MISO=%b busy=%b, expected 0 / 0", bus.MISO, dut.tx_busy_q);
        end
        bus.SS_n = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== 3'd0) begin
            errors++;
            $display("FAIL read_idle: state=%0d, expected 0", dut.state_q);
        end
    endtask

    task automatic test_abort();
        logic [9:0] f;
        int         pulses_before;
        f = 10'h0FF;
        pulses_before = pulse_cnt;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 5; i--) begin
            bus.MOSI = f[i];
            tick();
        end
        bus.SS_n = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== 3'd0 || bus.rx_valid !== 1'b0 || pulse_cnt != pulses_before) begin
            errors++;
            $display("FAIL abort: state=%0d rx_valid=%b pulses=%0d, expected 0 / 0 / %0d",
                     dut.state_q, bus.rx_valid, pulse_cnt, pulses_before);
        end
        start_frame(10'h0AA);
        end_frame();
    endtask

    task automatic test_reset_mid_readback();
        logic [9:0] f;
        f = 10'h212;
        start_frame(10'h212);
        end_frame();
        start_frame(10'h300);
        bus.MOSI = 1'b0;
        repeat (5) tick();              // E11..E15
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0 || dut.rd_addr_done_q !== 1'b0 ||
            dut.tx_busy_q !== 1'b0 || bus.rx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_readback: MISO=%b rx_valid=%b rd=%b busy=%b rx_data=%h, expected 0/0/0/0/000",
                     bus.MISO, bus.rx_valid, dut.rd_addr_done_q, dut.tx_busy_q, bus.rx_data);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        tick();
        bus.SS_n = 1'b0;
        tick();
        bus.MOSI = f[9];
        tick();
        checks++;
        if (dut.state_q !== 3'd3) begin
            errors++;
            $display("FAIL reset_then_read_add: state=%0d, expected 3", dut.state_q);
        end
        for (int i = 8; i >= 0; i--) begin
            bus.MOSI = f[i];
            tick();
        end
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== f || dut.rd_addr_done_q !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: rx_valid=%b rx_data=%h rd=%b, expected 1 / %h / 1",
                     bus.rx_valid, bus.rx_data, dut.rd_addr_done_q, f);
        end
        end_frame();
    endtask

    task automatic test_stray_tx();
        stray_data  = 8'hFF;
        stray_valid = 1'b1;
        tick();
        stray_valid = 1'b0;
        tick();
        checks++;
        if (bus.MISO !== 1'b0 || dut.tx_busy_q !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: MISO=%b busy=%b, expected 0 / 0", bus.MISO, dut.tx_busy_q);
        end
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI    = 1'b0;
            stray_valid = (i == 6);
            tick();
            if (i <= 5) begin
                checks++;
                if (bus.MISO !== 1'b0 || dut.tx_busy_q !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_write_bit%0d: MISO=%b busy=%b, expected 0 / 0", i, bus.MISO, dut.tx_busy_q);
                end
            end
        end
        stray_valid = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h000) begin
            errors++;
            $display("FAIL stray_write_frame: rx_valid=%b rx_data=%h, expected 1 / 000", bus.rx_valid, bus.rx_data);
        end
        end_frame();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pulse_cnt   = 0;
        rst_n       = 1'b0;
        bus.SS_n    = 1'b1;
        bus.MOSI    = 1'b0;
        stray_valid = 1'b0;
        stray_data  = 8'h00;
        test_reset();
        test_write();
        test_read_addr();
        test_read_data();
        test_abort();
        test_reset_mid_readback();
        test_stray_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
